alu_matrix_seq: RTL and testbench

//   Parametrised NxN matrix ALU with a start/busy/done handshake. Holds A, B and C register files.

---
 rtl/alu_matrix_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_matrix_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_matrix_seq.sv
// NxN matrix ALU: A/B/C register files, one element-op per clock, start/busy/done handshake.
// C is produced in row-major order; MUL walks an inner index k with a running accumulator.
module alu_matrix_seq #(
  parameter int N  = 3,
  parameter int DW = 32,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          wr_mat,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    op,
  input  logic [DW-1:0] scalar,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ovf,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam logic [AW:0]   NNW = (AW+1)'(NN);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                         OP_TRN = 3'd3, OP_SCL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, nxt;

  logic signed [DW-1:0] a_mem [NN];
  logic signed [DW-1:0] b_mem [NN];
  logic signed [DW-1:0] c_mem [NN];

  logic [2:0]           op_q;
  logic signed [DW-1:0] scalar_q, acc;
  logic [CW-1:0]        i, j, k;

  logic [AW-1:0]          idx, tidx, aik, bkj;
  logic signed [DW-1:0]   m_a, m_b, op_a, op_b, result;
  logic signed [2*DW-1:0] m_ea, m_eb, prod;
  logic signed [DW:0]     sum;
  logic                   prod_ovf, sum_ovf, elem_ovf, last_elem, op_legal, wr_ok, rd_ok;

  assign op_legal  = (op <= OP_SCL);
  assign wr_ok     = ({1'b0, wr_addr} < NNW);
  assign rd_ok     = ({1'b0, rd_addr} < NNW);
  assign last_elem = (i == NM1) && (j == NM1) && ((op_q != OP_MUL) || (k == NM1));
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // Element datapath: one shared multiplier (MUL / SCALE) and one widened adder (ADD / SUB / MAC).
  always_comb begin
    idx  = AW'(int'(i) * N + int'(j));
    tidx = AW'(int'(j) * N + int'(i));
    aik  = AW'(int'(i) * N + int'(k));
    bkj  = AW'(int'(k) * N + int'(j));

    m_a  = (op_q == OP_MUL) ? a_mem[aik] : a_mem[idx];
    m_b  = (op_q == OP_MUL) ? b_mem[bkj] : scalar_q;
    m_ea = m_a;
    m_eb = m_b;
    prod = m_ea * m_eb;
    prod_ovf = (prod != {{DW{prod[DW-1]}}, prod[DW-1:0]});

    op_a = a_mem[idx];
    op_b = b_mem[idx];
    if (op_q == OP_MUL) begin
      op_a = (k == '0) ? '0 : acc;
      op_b = prod[DW-1:0];
    end
    if (op_q == OP_SUB) sum = {op_a[DW-1], op_a} - {op_b[DW-1], op_b};
    else                sum = {op_a[DW-1], op_a} + {op_b[DW-1], op_b};
    sum_ovf = sum[DW] ^ sum[DW-1];

    result   = '0;
    elem_ovf = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin result = sum[DW-1:0];  elem_ovf = sum_ovf;            end
      OP_MUL:         begin result = sum[DW-1:0];  elem_ovf = prod_ovf | sum_ovf; end
      OP_TRN:         begin result = a_mem[tidx];  elem_ovf = 1'b0;               end
      OP_SCL:         begin result = prod[DW-1:0]; elem_ovf = prod_ovf;           end
      default:        begin result = '0;           elem_ovf = 1'b0;               end
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = op_legal ? S_RUN : S_DONE;
      S_RUN:   if (last_elem) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NN; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
      op_q     <= '0;
      scalar_q <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
      rd_data  <= '0;
    end else begin
      // A/B frozen while running; a write alongside start lands before the first element-op.
      if (wr_en && wr_ok && (state != S_RUN)) begin
        if (wr_mat) b_mem[wr_addr] <= wr_data;
        else        a_mem[wr_addr] <= wr_data;
      end
      rd_data <= rd_ok ? c_mem[rd_addr] : '0;

      case (state)
        S_IDLE: if (start) begin
          op_q     <= op;
          scalar_q <= scalar;
          i        <= '0;
          j        <= '0;
          k        <= '0;
          ovf      <= 1'b0;
          err      <= !op_legal;
        end
        S_RUN: begin
          acc <= result;
          if (elem_ovf) ovf <= 1'b1;
          if ((op_q != OP_MUL) || (k == NM1)) c_mem[idx] <= result;
          if ((op_q == OP_MUL) && (k != NM1)) begin
            k <= k + CW'(1);
          end else begin
            k <= '0;
            if (j == NM1) begin
              j <= '0;
              i <= i + CW'(1);
            end else begin
              j <= j + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_matrix_seq.sv
// Bench for alu_matrix_seq (N=3, DW=32): constant vector table, randomized ops against
// a plain-arithmetic matrix model, and hand sequences for handshake/reset corner cases.
module tb_alu_matrix_seq;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NN = 9;

  logic          clk = 0;
  logic          reset_n;
  logic          wr_en, wr_mat;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    op;
  logic [DW-1:0] scalar;
  logic          start;
  logic          busy, done, err, ovf;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  alu_matrix_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_mat(wr_mat), .wr_addr(wr_addr),
    .wr_data(wr_data), .op(op), .scalar(scalar), .start(start), .busy(busy), .done(done),
    .err(err), .ovf(ovf), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ma [NN];
  logic [31:0] mb [NN];
  logic [31:0] mc [NN];
  bit          m_ovf, m_err;
  int          m_cyc;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      sc;
    logic [8:0][31:0] c;
    logic             ovf;
    logic             err;
    logic [7:0]       cyc;
  } vec_t;
  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit fits(input longint v);
    return (v <= 64'sh7FFFFFFF) && (v >= -64'sh80000000);
  endfunction

  // Reference: whole-matrix results from the operation definitions.
  task automatic model_op(input logic [2:0] o, input logic [31:0] sc);
    longint s, p;
    logic [31:0] acc;
    m_ovf = 0; m_err = 0; m_cyc = NN;
    case (o)
      3'd0, 3'd1: for (int e = 0; e < NN; e++) begin
        s = (o == 3'd0) ? sx(ma[e]) + sx(mb[e]) : sx(ma[e]) - sx(mb[e]);
        m_ovf |= !fits(s);
        mc[e] = s[31:0];
      end
      3'd2: begin
        m_cyc = NN * N;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            acc = 0;
            for (int q = 0; q < N; q++) begin
              p = sx(ma[r*N+q]) * sx(mb[q*N+c]);
              m_ovf |= !fits(p);
              s = sx(acc) + sx(p[31:0]);
              m_ovf |= !fits(s);
              acc = s[31:0];
            end
            mc[r*N+c] = acc;
          end
      end
      3'd3: for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++) mc[r*N+c] = ma[c*N+r];
      3'd4: for (int e = 0; e < NN; e++) begin
        p = sx(ma[e]) * sx(sc);
        m_ovf |= !fits(p);
        mc[e] = p[31:0];
      end
      default: begin m_err = 1; m_cyc = 0; end
    endcase
  endtask

  task automatic model_clear();
    for (int e = 0; e < NN; e++) begin ma[e] = 0; mb[e] = 0; mc[e] = 0; end
  endtask

  task automatic write_el(input logic mat, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1; wr_mat = mat; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
    if (a < NN) begin
      if (mat) mb[a] = d;
      else     ma[a] = d;
    end
  endtask

  task automatic read_el(input logic [AW-1:0] a, output logic [31:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  // Issues start; while busy, scrambles op/scalar and fires writes that must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] sc, input bit hold,
                        output int cyc, output logic e, output logic v, output logic [31:0] rl);
    int guard;
    op = o; scalar = sc; start = 1;
    tick();
    if (!hold) start = 0;
    op = 3'($urandom); scalar = $urandom;
    cyc = 0; guard = 0;
    while (!done && guard < 200) begin
      if (busy) cyc++;
      wr_en = busy; wr_mat = 1'($urandom); wr_addr = AW'($urandom_range(0, NN-1));
      wr_data = $urandom;
      tick();
      guard++;
    end
    wr_en = 0; start = 0;
    check("done_seen", done, 1);
    check("done_with_busy_low", busy, 0);
    e = err; v = ovf;
    rd_addr = AW'(NN-1);
    tick();
    rl = rd_data;
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_c_model(input string name);
    logic [31:0] d;
    for (int x = 0; x < NN; x++) begin
      read_el(AW'(x), d);
      check(name, d, mc[x]);
    end
  endtask

  task automatic set_vec(input int r, input logic [2:0] o, input logic [31:0] sc,
                         input int t[9], input logic v, input logic e, input logic [7:0] cy);
    vt[r].op = o; vt[r].sc = sc; vt[r].ovf = v; vt[r].err = e; vt[r].cyc = cy;
    for (int x = 0; x < NN; x++) vt[r].c[x] = 32'(t[x]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t [9];
    int cyc;
    logic e, v;
    logic [31:0] rl, d, dat;
    logic [2:0] o;
    logic [31:0] sc;
    int nw, ad;
    logic mat;

    set_vec(0, 3'd3, 32'd0, '{0, 3, 6, 1, 4, 7, 2, 5, 8}, 1'b0, 1'b0, 8'd9);
    set_vec(1, 3'd2, 32'd0, '{15, 18, 21, 42, 54, 66, 69, 90, 111}, 1'b0, 1'b0, 8'd27);
    set_vec(2, 3'd0, 32'd0, '{0, 2, 4, 6, 8, 10, 12, 14, 16}, 1'b0, 1'b0, 8'd9);
    set_vec(3, 3'd1, 32'd0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 8'd9);
    set_vec(4, 3'd4, -32'sd2, '{0, -2, -4, -6, -8, -10, -12, -14, -16}, 1'b0, 1'b0, 8'd9);
    set_vec(5, 3'd7, 32'd0, '{0, -2, -4, -6, -8, -10, -12, -14, -16}, 1'b0, 1'b1, 8'd0);

    reset_n = 0; wr_en = 0; wr_mat = 0; wr_addr = 0; wr_data = 0;
    op = 0; scalar = 0; start = 0; rd_addr = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_ovf", ovf, 0);
    check("reset_rd_data", rd_data, 0);
    reset_n = 1;
    tick();

    for (int x = 0; x < NN; x++) begin
      write_el(1'b0, AW'(x), 32'(x));
      write_el(1'b1, AW'(x), 32'(x));
    end

    // Table vectors
    for (int r = 0; r < 6; r++) begin
      model_op(vt[r].op, vt[r].sc);
      run_op(vt[r].op, vt[r].sc, 1'b0, cyc, e, v, rl);
      check($sformatf("vec%0d_cycles", r), cyc, vt[r].cyc);
      check($sformatf("vec%0d_err", r), e, vt[r].err);
      check($sformatf("vec%0d_ovf", r), v, vt[r].ovf);
      check($sformatf("vec%0d_read_in_done", r), rl, vt[r].c[8]);
      for (int x = 0; x < NN; x++) begin
        read_el(AW'(x), d);
        check($sformatf("vec%0d_c%0d", r, x), d, vt[r].c[x]);
      end
    end

    // start held through busy: one op, one done, no restart
    model_op(3'd0, 0);
    run_op(3'd0, 0, 1'b1, cyc, e, v, rl);
    check("hold_cycles", cyc, 9);
    for (int x = 0; x < 3; x++) begin
      tick();
      check("hold_no_extra_done", done, 0);
      check("hold_no_restart", busy, 0);
    end
    check_c_model("hold_c");

    // signed overflow on ADD, then cleared by the next start
    write_el(1'b0, 0, 32'h7FFFFFFF);
    write_el(1'b1, 0, 32'h1);
    model_op(3'd0, 0);
    run_op(3'd0, 0, 1'b0, cyc, e, v, rl);
    check("ovf_add_flag", v, 1);
    read_el(0, d);
    check("ovf_add_c0", d, 32'h80000000);
    model_op(3'd3, 0);
    run_op(3'd3, 0, 1'b0, cyc, e, v, rl);
    check("ovf_cleared", v, 0);
    check_c_model("trans_after_ovf");

    // write in the same cycle as start is seen by the op
    wr_en = 1; wr_mat = 1; wr_addr = 2; wr_data = 32'd50;
    mb[2] = 32'd50;
    model_op(3'd0, 0);
    run_op(3'd0, 0, 1'b0, cyc, e, v, rl);
    check("wr_start_ovf", v, m_ovf);
    check_c_model("wr_start_c");

    // randomized ops against the model
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        ad = $urandom_range(0, NN-1);
        mat = 1'($urandom_range(0, 1));
        dat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
        write_el(mat, AW'(ad), dat);
      end
      o  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      sc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      model_op(o, sc);
      run_op(o, sc, 1'b0, cyc, e, v, rl);
      check($sformatf("rnd%0d_op%0d_cycles", it, o), cyc, m_cyc);
      check($sformatf("rnd%0d_op%0d_err", it, o), e, m_err);
      check($sformatf("rnd%0d_op%0d_ovf", it, o), v, m_ovf);
      check($sformatf("rnd%0d_op%0d_read_in_done", it, o), rl, mc[8]);
      check_c_model($sformatf("rnd%0d_op%0d_c", it, o));
    end

    // reset asserted in cycle 10 of a MUL
    for (int x = 0; x < NN; x++) begin
      write_el(1'b0, AW'(x), 32'(x));
      write_el(1'b1, AW'(x), 32'(x));
    end
    op = 3'd2; start = 1;
    tick();
    start = 0;
    repeat (9) tick();
    check("mul_busy_before_reset", busy, 1);
    reset_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    model_clear();
    #3;
    reset_n = 1;
    for (int x = 0; x < 3; x++) begin
      tick();
      check("abort_no_done", done, 0);
    end
    check_c_model("abort_c_cleared");

    // out-of-range addresses
    write_el(1'b0, 4'd9, 32'h1234);
    write_el(1'b1, 4'd15, 32'h5678);
    read_el(4'd9, d);
    check("oob_read_9", d, 0);
    model_op(3'd0, 0);
    run_op(3'd0, 0, 1'b0, cyc, e, v, rl);
    check_c_model("oob_write_ignored");
    read_el(4'd9, d);
    check("oob_read_after_op", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
